nyakuo_decoder: RTL and testbench

Instruction decode stage of the nyakuo RV32I core. Accepts raw 32-bit instruction words and their PCs from fetch over a valid/ready handshake. Classifies each word into the shared `instruction` enum and extracts register indices and a sign-extended immediate. Presents the result to execute through a registered output stage with a one-entry skid buffer, so both handshake directions are fully registered.

---
 rtl/nyakuo_pkg.sv | 42 ++++
 rtl/nyakuo_decode_comb.sv | 145 ++++++++++++++
 rtl/nyakuo_decoder.sv | 75 +++++++
 tb/tb_nyakuo_decoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nyakuo_pkg.sv
// Shared nyakuo core types: instruction enum, RV32I opcode map and the decoded-entry record.
package nyakuo_pkg;

  typedef enum logic [5:0] {
    INVALID,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, FENCE_I, ECALL, EBREAK,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
  } instruction;

  // Major opcodes, inst[6:2]
  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_MISCMEM = 5'b00011;
  localparam logic [4:0] OP_OPIMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_OP      = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_SYSTEM  = 5'b11100;

  typedef struct packed {
    instruction  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } decoded_t;

  localparam decoded_t DECODED_RESET = '{op: INVALID, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                                         imm: 32'd0, pc: 32'd0, illegal: 1'b0};

endpackage

// File: rtl/nyakuo_decode_comb.sv
// Combinational RV32I word classifier: op enum, raw register fields, sign-extended immediate.
module nyakuo_decode_comb
  import nyakuo_pkg::*;
#(
  parameter bit SUPPORT_SYSTEM = 1'b0
) (
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output decoded_t    o_dec
);

  logic [4:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  instruction  w_op;
  logic [31:0] w_imm;

  assign w_opc    = i_inst[6:2];
  assign w_f3     = i_inst[14:12];
  assign w_f7     = i_inst[31:25];
  assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u  = {i_inst[31:12], 12'b0};
  assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_imm_sh = {27'b0, i_inst[24:20]};

  always_comb begin
    w_op  = INVALID;
    w_imm = '0;
    if (i_inst[1:0] == 2'b11) begin
      case (w_opc)
        OP_LUI:   begin w_op = LUI;   w_imm = w_imm_u; end
        OP_AUIPC: begin w_op = AUIPC; w_imm = w_imm_u; end
        OP_JAL:   begin w_op = JAL;   w_imm = w_imm_j; end
        OP_JALR: begin
          w_imm = w_imm_i;
          if (w_f3 == 3'b000) w_op = JALR;
        end
        OP_BRANCH: begin
          w_imm = w_imm_b;
          case (w_f3)
            3'b000: w_op = BEQ;
            3'b001: w_op = BNE;
            3'b100: w_op = BLT;
            3'b101: w_op = BGE;
            3'b110: w_op = BLTU;
            3'b111: w_op = BGEU;
            default: ;
          endcase
        end
        OP_LOAD: begin
          w_imm = w_imm_i;
          case (w_f3)
            3'b000: w_op = LB;
            3'b001: w_op = LH;
            3'b010: w_op = LW;
            3'b100: w_op = LBU;
            3'b101: w_op = LHU;
            default: ;
          endcase
        end
        OP_STORE: begin
          w_imm = w_imm_s;
          case (w_f3)
            3'b000: w_op = SB;
            3'b001: w_op = SH;
            3'b010: w_op = SW;
            default: ;
          endcase
        end
        OP_OPIMM: begin
          w_imm = w_imm_i;
          case (w_f3)
            3'b000: w_op = ADDI;
            3'b010: w_op = SLTI;
            3'b011: w_op = SLTIU;
            3'b100: w_op = XORI;
            3'b110: w_op = ORI;
            3'b111: w_op = ANDI;
            3'b001: begin
              w_imm = w_imm_sh;
              if (w_f7 == 7'b0000000) w_op = SLLI;
            end
            default: begin
              w_imm = w_imm_sh;
              if (w_f7 == 7'b0000000)      w_op = SRLI;
              else if (w_f7 == 7'b0100000) w_op = SRAI;
            end
          endcase
        end
        OP_OP: begin
          if (w_f7 == 7'b0000000) begin
            case (w_f3)
              3'b000: w_op = ADD;
              3'b001: w_op = SLL;
              3'b010: w_op = SLT;
              3'b011: w_op = SLTU;
              3'b100: w_op = XOR;
              3'b101: w_op = SRL;
              3'b110: w_op = OR;
              default: w_op = AND;
            endcase
          end else if (w_f7 == 7'b0100000) begin
            if (w_f3 == 3'b000)      w_op = SUB;
            else if (w_f3 == 3'b101) w_op = SRA;
          end
        end
        OP_MISCMEM: begin
          w_imm = w_imm_i;
          if (SUPPORT_SYSTEM) begin
            if (w_f3 == 3'b000)      w_op = FENCE;
            else if (w_f3 == 3'b001) w_op = FENCE_I;
          end
        end
        OP_SYSTEM: begin
          w_imm = w_imm_i;
          if (SUPPORT_SYSTEM) begin
            case (w_f3)
              3'b000: begin
                // ECALL/EBREAK are single exact encodings; anything else under funct3=0 is illegal
                if (i_inst[31:7] == 25'h0000000)      w_op = ECALL;
                else if (i_inst[31:7] == 25'h0002000) w_op = EBREAK;
              end
              3'b001: w_op = CSRRW;
              3'b010: w_op = CSRRS;
              3'b011: w_op = CSRRC;
              3'b101: w_op = CSRRWI;
              3'b110: w_op = CSRRSI;
              3'b111: w_op = CSRRCI;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
    if (w_op == INVALID) w_imm = '0;
  end

  assign o_dec = '{op: w_op, rd: i_inst[11:7], rs1: i_inst[19:15], rs2: i_inst[24:20],
                   imm: w_imm, pc: i_pc, illegal: (w_op == INVALID)};

endmodule

// File: rtl/nyakuo_decoder.sv
// Decode stage: combinational decode feeding a registered output slot backed by a one-entry skid buffer.
module nyakuo_decoder
  import nyakuo_pkg::*;
#(
  parameter bit SUPPORT_SYSTEM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_op,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  decoded_t w_dec;
  decoded_t r_out, r_skid;
  logic     r_out_valid, r_skid_valid;
  logic     w_in_xfer, w_out_free;

  nyakuo_decode_comb #(.SUPPORT_SYSTEM(SUPPORT_SYSTEM)) u_decode (
    .i_inst (in_inst),
    .i_pc   (in_pc),
    .o_dec  (w_dec)
  );

  // in_ready comes straight from the skid flop, so no comb path from out_ready to in_ready
  assign w_in_xfer  = in_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= DECODED_RESET;
      r_skid       <= DECODED_RESET;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= w_in_xfer;
        if (w_in_xfer) r_skid <= w_dec;
      end else begin
        r_out_valid <= w_in_xfer;
        if (w_in_xfer) r_out <= w_dec;
      end
    end else if (w_in_xfer) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign in_ready    = !r_skid_valid;
  assign out_valid   = r_out_valid;
  assign out_op      = r_out.op;
  assign out_rd      = r_out.rd;
  assign out_rs1     = r_out.rs1;
  assign out_rs2     = r_out.rs2;
  assign out_imm     = r_out.imm;
  assign out_pc      = r_out.pc;
  assign out_illegal = r_out.illegal;

endmodule

// File: tb/tb_nyakuo_decoder.sv
// Scoreboard bench: two decoders (system ops off/on) share stimulus; a negedge monitor pops expected entries.
module tb_nyakuo_decoder;
  import nyakuo_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc;
    logic        illegal;
  } exp_t;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        in_ready0, out_valid0, out_illegal0;
  logic        in_ready1, out_valid1, out_illegal1;
  logic [5:0]  out_op0, out_op1;
  logic [4:0]  out_rd0, out_rs10, out_rs20, out_rd1, out_rs11, out_rs21;
  logic [31:0] out_imm0, out_pc0, out_imm1, out_pc1;

  nyakuo_decoder #(.SUPPORT_SYSTEM(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_op(out_op0), .out_rd(out_rd0), .out_rs1(out_rs10), .out_rs2(out_rs20),
    .out_imm(out_imm0), .out_pc(out_pc0), .out_illegal(out_illegal0)
  );

  nyakuo_decoder #(.SUPPORT_SYSTEM(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_op(out_op1), .out_rd(out_rd1), .out_rs1(out_rs11), .out_rs2(out_rs21),
    .out_imm(out_imm1), .out_pc(out_pc1), .out_illegal(out_illegal1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seq = 0;
  int cur_idx = 0;
  bit started = 0;

  logic [31:0] v_word[16];
  logic [5:0]  v_op0[16];
  logic [5:0]  v_op1[16];
  logic [31:0] v_imm[16];

  exp_t q0[$];
  exp_t q1[$];
  exp_t e_mon;
  logic        stall_prev;
  logic [31:0] held_imm, held_pc;
  logic [5:0]  held_op;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected progress", nm);
  endtask

  task automatic chk_entry(input string nm, input exp_t e, input logic [5:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                           input logic [31:0] pc, input logic il);
    checks++;
    if (op !== e.op || rd !== e.rd || rs1 !== e.rs1 || rs2 !== e.rs2 || imm !== e.imm ||
        pc !== e.pc || il !== e.illegal) begin
      failures++;
      $display("FAIL %s pc=%h: got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h ill=%b expected op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h ill=%b",
               nm, e.pc, op, rd, rs1, rs2, imm, pc, il,
               e.op, e.rd, e.rs1, e.rs2, e.imm, e.pc, e.illegal);
    end else begin
      $display("%s pc=%h op=%0d imm=%h ill=%b ok", nm, pc, op, imm, il);
    end
  endtask

  function automatic exp_t make_exp(input int idx, input bit sys, input logic [31:0] pc);
    exp_t e;
    logic [31:0] w;
    w         = v_word[idx];
    e.op      = sys ? v_op1[idx] : v_op0[idx];
    e.illegal = (e.op == 6'(INVALID));
    e.imm     = e.illegal ? 32'h0 : v_imm[idx];
    e.rd      = w[11:7];
    e.rs1     = w[19:15];
    e.rs2     = w[24:20];
    e.pc      = pc;
    return e;
  endfunction

  // Monitor: transfers are decided by the values settled at this negedge, taking effect next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      stall_prev <= 1'b0;
    end else if (started) begin
      if (flush) begin
        q0.delete();
        q1.delete();
        stall_prev <= 1'b0;
      end else begin
        if (out_valid0 && out_ready) begin
          if (q0.size() == 0) fail_now("dut0_unexpected_output");
          else begin
            e_mon = q0.pop_front();
            chk_entry("dut0", e_mon, out_op0, out_rd0, out_rs10, out_rs20, out_imm0, out_pc0, out_illegal0);
          end
        end
        if (out_valid1 && out_ready) begin
          if (q1.size() == 0) fail_now("dut1_unexpected_output");
          else begin
            e_mon = q1.pop_front();
            chk_entry("dut1", e_mon, out_op1, out_rd1, out_rs11, out_rs21, out_imm1, out_pc1, out_illegal1);
          end
        end
        if (out_valid0 && !out_ready) begin
          if (stall_prev) begin
            chk("hold_op", 32'(out_op0), 32'(held_op));
            chk("hold_imm", out_imm0, held_imm);
            chk("hold_pc", out_pc0, held_pc);
          end
          stall_prev <= 1'b1;
          held_op    <= out_op0;
          held_imm   <= out_imm0;
          held_pc    <= out_pc0;
        end else begin
          stall_prev <= 1'b0;
        end
        if (in_valid && in_ready0) begin
          q0.push_back(make_exp(cur_idx, 1'b0, in_pc));
          q1.push_back(make_exp(cur_idx, 1'b1, in_pc));
        end
      end
    end
  end

  task automatic setv(input int i, input logic [31:0] w, input instruction o0, input instruction o1,
                      input logic [31:0] imm);
    v_word[i] = w;
    v_op0[i]  = 6'(o0);
    v_op1[i]  = 6'(o1);
    v_imm[i]  = imm;
  endtask

  task automatic send(input int idx);
    int n;
    n        = 0;
    cur_idx  = idx;
    in_inst  = v_word[idx];
    in_pc    = 32'h1000 + 32'(seq * 4);
    seq++;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready0) break;
      n++;
      if (n > 40) begin
        fail_now("send_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || out_valid0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    setv(0,  32'h00500093, ADDI,    ADDI,   32'h00000005);
    setv(1,  32'hFE000EE3, BEQ,     BEQ,    32'hFFFFFFFC);
    setv(2,  32'h123452B7, LUI,     LUI,    32'h12345000);
    setv(3,  32'h00000000, INVALID, INVALID, 32'h0);
    setv(4,  32'h00000073, INVALID, ECALL,  32'h0);
    setv(5,  32'h402081B3, SUB,     SUB,    32'h0);
    setv(6,  32'h4030D093, SRAI,    SRAI,   32'h00000003);
    setv(7,  32'h0020A423, SW,      SW,     32'h00000008);
    setv(8,  32'hFF9FF0EF, JAL,     JAL,    32'hFFFFFFF8);
    setv(9,  32'h02009093, INVALID, INVALID, 32'h0);
    setv(10, 32'h00003083, INVALID, INVALID, 32'h0);
    setv(11, 32'h00002063, INVALID, INVALID, 32'h0);
    setv(12, 32'h00100073, INVALID, EBREAK, 32'h00000001);
    setv(13, 32'h300110F3, INVALID, CSRRW,  32'h00000300);
    setv(14, 32'h00000001, INVALID, INVALID, 32'h0);
    setv(15, 32'hFFF12283, LW,      LW,     32'hFFFFFFFF);

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_in_ready_sys", 32'(in_ready1), 32'd1);
    chk("rst_op", 32'(out_op0), 32'(INVALID));
    chk("rst_illegal", 32'(out_illegal0), 32'd0);
    chk("rst_imm", out_imm0, 32'd0);
    chk("rst_pc", out_pc0, 32'd0);
    chk("rst_rd", 32'(out_rd0), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1'b1;

    // single word: visible right after the accepting edge
    send(0);
    chk("lat_valid", 32'(out_valid0), 32'd1);
    chk("lat_op", 32'(out_op0), 32'(ADDI));

    // back-to-back stream: one word per cycle
    c0 = cyc;
    for (int i = 1; i < 16; i++) send(i);
    chk("throughput_cycles", 32'(cyc - c0), 32'd15);
    drain();

    // stall: OUT then SKID fill, third word waits for space
    out_ready = 1'b0;
    send(2);
    send(5);
    chk("full_in_ready", 32'(in_ready0), 32'd0);
    chk("full_out_valid", 32'(out_valid0), 32'd1);
    in_inst = v_word[7]; cur_idx = 7; in_pc = 32'h1000 + 32'(seq * 4); in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stalled_in_ready", 32'(in_ready0), 32'd0);
    out_ready = 1'b1;
    seq--;
    send(7);
    drain();

    // flush while full, with a concurrent input attempt
    out_ready = 1'b0;
    send(0);
    send(1);
    in_inst = v_word[2]; cur_idx = 2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid0), 32'd0);
    chk("flush_in_ready", 32'(in_ready0), 32'd1);
    chk("flush_out_valid_sys", 32'(out_valid1), 32'd0);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_quiet", 32'(out_valid0), 32'd0);
    end
    @(posedge clk);
    #1;
    send(6);
    drain();

    // reset in the middle of a stall
    out_ready = 1'b0;
    send(8);
    send(12);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid0), 32'd0);
    chk("midrst_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(13);
    drain();

    chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
